// File: rtl/tlc_pkg.sv
// Shared definitions for the tlc detector front end: light codes,
// default timing parameters and the light-code legality check.
package tlc_pkg;

  // tlc light outputs are coded {red,green,yellow}, one-hot
  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] GREEN  = 3'b010;
  localparam logic [2:0] YELLOW = 3'b001;

  // Default timing and sizing
  localparam int DEB_CYC_DEF    = 4;   // cycles a detector level must persist
  localparam int CNT_W_DEF      = 4;   // queue counter width
  localparam int DEPART_CYC_DEF = 3;   // green cycles per departed vehicle
  localparam int MAX_GREEN_DEF  = 16;  // green cycles before starvation guard

  // True only for the three defined one-hot light codes
  function automatic logic legal_light(input logic [2:0] code);
    return (code == RED) || (code == GREEN) || (code == YELLOW);
  endfunction

endpackage

// File: rtl/tlc_det_lane.sv
// One detector lane: two-flop synchroniser, debounce, queue counter with
// saturation/overflow, departure timer and saturating green counter.
module tlc_det_lane
  import tlc_pkg::*;
#(
  parameter int DEB_CYC    = DEB_CYC_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int DEPART_CYC = DEPART_CYC_DEF,
  parameter int MAX_GREEN  = MAX_GREEN_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             det,
  input  logic [2:0]       light,
  output logic [CNT_W-1:0] qcnt,
  output logic             ovf,
  output logic             green_sat
);

  localparam int DEB_W = (DEB_CYC    > 1) ? $clog2(DEB_CYC)    : 1;
  localparam int DEP_W = (DEPART_CYC > 1) ? $clog2(DEPART_CYC) : 1;
  localparam int GRN_W = $clog2(MAX_GREEN + 1);

  // Last count value before the debounced level flips / a departure fires
  localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYC - 1);
  localparam logic [DEP_W-1:0] DEP_LAST  = DEP_W'(DEPART_CYC - 1);
  localparam logic [GRN_W-1:0] GRN_MAX   = GRN_W'(MAX_GREEN);
  localparam logic [CNT_W-1:0] QCNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] QCNT_ZERO = '0;

  logic             sync1;
  logic             sync2;
  logic             deb_lvl;
  logic [DEB_W-1:0] deb_cnt;
  logic [DEP_W-1:0] dep_cnt;
  logic [GRN_W-1:0] grn_cnt;
  logic             is_green;
  logic             arrival;
  logic             departure;
  logic             dep_eff;

  assign is_green = (light == GREEN);

  // Arrival is the 0->1 flip of the debounced level, seen in the same cycle
  // the flip is committed so the queue updates on the flipping edge.
  assign arrival   = sync2 && !deb_lvl && (deb_cnt == DEB_LAST);
  assign departure = is_green && (dep_cnt == DEP_LAST);
  // A departure from an empty queue has nothing to remove
  assign dep_eff   = departure && (qcnt != QCNT_ZERO);

  assign green_sat = (grn_cnt == GRN_MAX);

  // Two-flop synchroniser for the asynchronous detector input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= det;
      sync2 <= sync1;
    end
  end

  // Debounce: count a persistent mismatch, flip the level after DEB_CYC cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt <= '0;
      deb_lvl <= 1'b0;
    end else if (sync2 == deb_lvl) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      deb_cnt <= '0;
      deb_lvl <= sync2;
    end else begin
      deb_cnt <= deb_cnt + DEB_W'(1);
    end
  end

  // Departure timer: runs on continuous green, wraps every DEPART_CYC cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dep_cnt <= '0;
    end else if (!is_green || (dep_cnt == DEP_LAST)) begin
      dep_cnt <= '0;
    end else begin
      dep_cnt <= dep_cnt + DEP_W'(1);
    end
  end

  // Green counter: saturating count of continuous green cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grn_cnt <= '0;
    end else if (!is_green) begin
      grn_cnt <= '0;
    end else if (grn_cnt != GRN_MAX) begin
      grn_cnt <= grn_cnt + GRN_W'(1);
    end
  end

  // Queue counter: arrival and departure together cancel; a lost arrival
  // at saturation latches the overflow flag until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qcnt <= '0;
      ovf  <= 1'b0;
    end else begin
      case ({arrival, dep_eff})
        2'b10: begin
          if (qcnt == QCNT_MAX) begin
            ovf <= 1'b1;
          end else begin
            qcnt <= qcnt + CNT_W'(1);
          end
        end
        2'b01:   qcnt <= qcnt - CNT_W'(1);
        default: qcnt <= qcnt;
      endcase
    end
  end

endmodule

// File: rtl/tlc_sensor_if.sv
// Detector front end for the two-road traffic light controller. Two
// detector lanes feed queue counts; this level turns them into the tlc
// demand inputs with a starvation guard and checks the tlc light outputs.
module tlc_sensor_if
  import tlc_pkg::*;
#(
  parameter int DEB_CYC    = DEB_CYC_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int DEPART_CYC = DEPART_CYC_DEF,
  parameter int MAX_GREEN  = MAX_GREEN_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             detA,
  input  logic             detB,
  input  logic [2:0]       lightA,
  input  logic [2:0]       lightB,
  output logic             holdA,
  output logic             holdB,
  output logic [CNT_W-1:0] qcntA,
  output logic [CNT_W-1:0] qcntB,
  output logic             ovfA,
  output logic             ovfB,
  output logic             conflict
);

  localparam logic [CNT_W-1:0] QCNT_ZERO = '0;

  logic green_sat_a;
  logic green_sat_b;
  logic starve_a;
  logic starve_b;
  logic conflict_cond;

  tlc_det_lane #(
    .DEB_CYC   (DEB_CYC),
    .CNT_W     (CNT_W),
    .DEPART_CYC(DEPART_CYC),
    .MAX_GREEN (MAX_GREEN)
  ) u_lane_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .det      (detA),
    .light    (lightA),
    .qcnt     (qcntA),
    .ovf      (ovfA),
    .green_sat(green_sat_a)
  );

  tlc_det_lane #(
    .DEB_CYC   (DEB_CYC),
    .CNT_W     (CNT_W),
    .DEPART_CYC(DEPART_CYC),
    .MAX_GREEN (MAX_GREEN)
  ) u_lane_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .det      (detB),
    .light    (lightB),
    .qcnt     (qcntB),
    .ovf      (ovfB),
    .green_sat(green_sat_b)
  );

  // A road that has been green for MAX_GREEN cycles yields to a waiting road
  assign starve_a = green_sat_a && (qcntB != QCNT_ZERO);
  assign starve_b = green_sat_b && (qcntA != QCNT_ZERO);

  // Illegal codes, two greens, or green against yellow
  always_comb begin
    conflict_cond = 1'b0;
    if (!legal_light(lightA) || !legal_light(lightB)) begin
      conflict_cond = 1'b1;
    end else if ((lightA == GREEN) && ((lightB == GREEN) || (lightB == YELLOW))) begin
      conflict_cond = 1'b1;
    end else if ((lightB == GREEN) && (lightA == YELLOW)) begin
      conflict_cond = 1'b1;
    end
  end

  // Registered demand outputs, one edge behind the queue counts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      holdA <= 1'b0;
      holdB <= 1'b0;
    end else begin
      holdA <= (qcntA != QCNT_ZERO) && !starve_a;
      holdB <= (qcntB != QCNT_ZERO) && !starve_b;
    end
  end

  // Registered level conflict flag, follows the condition one edge later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict <= 1'b0;
    end else begin
      conflict <= conflict_cond;
    end
  end

endmodule

// File: tb/tb_tlc_sensor_if.sv
// Directed bench for tlc_sensor_if: inputs driven and outputs sampled on the
// falling edge, so "after edge n" means the negedge following rising edge n.
module tb_tlc_sensor_if;
  import tlc_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       detA;
  logic       detB;
  logic [2:0] lightA;
  logic [2:0] lightB;
  logic       holdA;
  logic       holdB;
  logic [3:0] qcntA;
  logic [3:0] qcntB;
  logic       ovfA;
  logic       ovfB;
  logic       conflict;

  int errors;
  int checks;
  logic [3:0] exp_q[$];

  tlc_sensor_if dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .detA    (detA),
    .detB    (detB),
    .lightA  (lightA),
    .lightB  (lightB),
    .holdA   (holdA),
    .holdB   (holdB),
    .qcntA   (qcntA),
    .qcntB   (qcntB),
    .ovfA    (ovfA),
    .ovfB    (ovfB),
    .conflict(conflict)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "time limit");
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    detA   = 1'b0;
    detB   = 1'b0;
    lightA = RED;
    lightB = RED;
    step(2);
    rst_n = 1'b1;
  endtask

  // One clean debounced vehicle on the selected lanes
  task automatic arrive(input logic a, input logic b);
    detA = a;
    detB = b;
    step(8);
    detA = 1'b0;
    detB = 1'b0;
    step(8);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n  = 1'b0;
    detA   = 1'b0;
    detB   = 1'b0;
    lightA = RED;
    lightB = RED;
    step(2);
    checks++;
    if ({holdA, holdB, qcntA, qcntB, ovfA, ovfB, conflict} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0",
               {holdA, holdB, qcntA, qcntB, ovfA, ovfB, conflict});
    end
    rst_n = 1'b1;
    detA  = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      step(1);
      if (n == 5 || n == 6) begin
        checks++;
        if (qcntA !== ((n == 6) ? 4'd1 : 4'd0)) begin
          errors++;
          $display("FAIL arrival_latency edge %0d: got qcntA=%0d expected %0d",
                   n, qcntA, (n == 6) ? 1 : 0);
        end
      end
      if (n == 6 || n == 7) begin
        checks++;
        if (holdA !== (n == 7)) begin
          errors++;
          $display("FAIL hold_lag edge %0d: got holdA=%0b expected %0b", n, holdA, n == 7);
        end
      end
    end
    checks++;
    if (qcntB !== 4'd0 || holdB !== 1'b0) begin
      errors++;
      $display("FAIL lane_b_idle: got qcntB=%0d holdB=%0b expected 0 0", qcntB, holdB);
    end
    detA = 1'b0;
  endtask

  task automatic test_glitch();
    do_reset();
    repeat (3) begin
      detB = 1'b1;
      step(3);
      detB = 1'b0;
      step(6);
    end
    checks++;
    if (qcntB !== 4'd0 || holdB !== 1'b0) begin
      errors++;
      $display("FAIL glitch_reject: got qcntB=%0d holdB=%0b expected 0 0", qcntB, holdB);
    end
    // A pulse of exactly DEB_CYC cycles is accepted
    detB = 1'b1;
    step(4);
    detB = 1'b0;
    step(8);
    checks++;
    if (qcntB !== 4'd1 || holdB !== 1'b1) begin
      errors++;
      $display("FAIL min_pulse_accept: got qcntB=%0d holdB=%0b expected 1 1", qcntB, holdB);
    end
  endtask

  task automatic test_departure();
    logic [3:0] e;
    do_reset();
    arrive(1'b1, 1'b0);
    arrive(1'b1, 1'b0);
    checks++;
    if (qcntA !== 4'd2 || holdA !== 1'b1) begin
      errors++;
      $display("FAIL depart_setup: got qcntA=%0d holdA=%0b expected 2 1", qcntA, holdA);
    end
    exp_q = '{4'd2, 4'd2, 4'd1, 4'd1, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0};
    lightA = GREEN;
    lightB = RED;
    for (int n = 1; n <= 9; n++) begin
      step(1);
      e = exp_q.pop_front();
      checks++;
      if (qcntA !== e) begin
        errors++;
        $display("FAIL departure edge %0d: got qcntA=%0d expected %0d", n, qcntA, e);
      end
      if (n == 6 || n == 7) begin
        checks++;
        if (holdA !== (n == 6)) begin
          errors++;
          $display("FAIL depart_hold edge %0d: got holdA=%0b expected %0b", n, holdA, n == 6);
        end
      end
    end
    lightA = RED;
  endtask

  task automatic test_overflow();
    do_reset();
    repeat (15) arrive(1'b1, 1'b0);
    checks++;
    if (qcntA !== 4'd15 || ovfA !== 1'b0) begin
      errors++;
      $display("FAIL fill_15: got qcntA=%0d ovfA=%0b expected 15 0", qcntA, ovfA);
    end
    arrive(1'b1, 1'b0);
    checks++;
    if (qcntA !== 4'd15 || ovfA !== 1'b1) begin
      errors++;
      $display("FAIL overflow: got qcntA=%0d ovfA=%0b expected 15 1", qcntA, ovfA);
    end
    // Arrival lands on edge 6; green starts after edge 3 so edge 6 departs too
    detA = 1'b1;
    step(3);
    lightA = GREEN;
    step(2);
    checks++;
    if (qcntA !== 4'd15) begin
      errors++;
      $display("FAIL pre_simul: got qcntA=%0d expected 15", qcntA);
    end
    step(1);
    checks++;
    if (qcntA !== 4'd15 || ovfA !== 1'b1) begin
      errors++;
      $display("FAIL simul_arr_dep: got qcntA=%0d ovfA=%0b expected 15 1", qcntA, ovfA);
    end
    step(3);
    checks++;
    if (qcntA !== 4'd14) begin
      errors++;
      $display("FAIL depart_after_sat: got qcntA=%0d expected 14", qcntA);
    end
    detA = 1'b0;
  endtask

  task automatic test_midop_reset();
    // Continues from the overflow state: qcntA=14, ovfA=1, holdA=1
    lightB = 3'b111;
    step(1);
    checks++;
    if (conflict !== 1'b1) begin
      errors++;
      $display("FAIL midop_conflict_set: got %0b expected 1", conflict);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (qcntA !== 4'd0 || ovfA !== 1'b0 || holdA !== 1'b0 || conflict !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got qcntA=%0d ovfA=%0b holdA=%0b conflict=%0b expected 0 0 0 0",
               qcntA, ovfA, holdA, conflict);
    end
    @(negedge clk);
    lightA = RED;
    lightB = RED;
    step(1);
    rst_n = 1'b1;
  endtask

  task automatic test_starvation();
    do_reset();
    arrive(1'b1, 1'b1);
    repeat (9) arrive(1'b1, 1'b0);
    checks++;
    if (qcntA !== 4'd10 || qcntB !== 4'd1 || holdA !== 1'b1 || holdB !== 1'b1) begin
      errors++;
      $display("FAIL starve_setup: got qcntA=%0d qcntB=%0d holdA=%0b holdB=%0b expected 10 1 1 1",
               qcntA, qcntB, holdA, holdB);
    end
    lightA = GREEN;
    for (int n = 1; n <= 18; n++) begin
      step(1);
      checks++;
      if (holdB !== 1'b1) begin
        errors++;
        $display("FAIL starve_holdB edge %0d: got %0b expected 1", n, holdB);
      end
      if (n == 16) begin
        checks++;
        if (holdA !== 1'b1) begin
          errors++;
          $display("FAIL starve_before edge 16: got holdA=%0b expected 1", holdA);
        end
      end
      if (n == 17) begin
        checks++;
        if (holdA !== 1'b0 || qcntA !== 4'd5) begin
          errors++;
          $display("FAIL starve_drop edge 17: got holdA=%0b qcntA=%0d expected 0 5",
                   holdA, qcntA);
        end
      end
    end
    lightA = RED;
  endtask

  task automatic test_conflict();
    logic [2:0] va [8];
    logic [2:0] vb [8];
    logic       vc [8];
    do_reset();
    checks++;
    if (conflict !== 1'b0) begin
      errors++;
      $display("FAIL conflict_idle: got %0b expected 0", conflict);
    end
    lightA = GREEN;
    lightB = GREEN;
    for (int n = 1; n <= 3; n++) begin
      step(1);
      if (n == 2) lightB = RED;
      checks++;
      if (conflict !== (n <= 2)) begin
        errors++;
        $display("FAIL double_green edge %0d: got %0b expected %0b", n, conflict, n <= 2);
      end
    end
    va = '{3'b011, 3'b001, 3'b010, 3'b001, 3'b100, 3'b000, 3'b010, 3'b100};
    vb = '{3'b100, 3'b001, 3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b110};
    vc = '{1'b1,   1'b0,   1'b1,   1'b1,   1'b0,   1'b1,   1'b0,   1'b1};
    for (int i = 0; i < 8; i++) begin
      lightA = va[i];
      lightB = vb[i];
      step(1);
      checks++;
      if (conflict !== vc[i]) begin
        errors++;
        $display("FAIL conflict_vec %0d (A=%b B=%b): got %0b expected %0b",
                 i, va[i], vb[i], conflict, vc[i]);
      end
    end
    lightA = RED;
    lightB = RED;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    detA   = 1'b0;
    detB   = 1'b0;
    lightA = RED;
    lightB = RED;
    @(negedge clk);
    test_reset();
    test_glitch();
    test_departure();
    test_overflow();
    test_midop_reset();
    test_starvation();
    test_conflict();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
